// File: rtl/arm_pkg.sv
// Shared definitions for the ARM condition/flags stage: condition field
// encodings and NZCV bit positions.
package arm_pkg;

  typedef logic [3:0] cond_t;

  localparam cond_t COND_EQ  = 4'b0000;
  localparam cond_t COND_NE  = 4'b0001;
  localparam cond_t COND_CS  = 4'b0010;
  localparam cond_t COND_CC  = 4'b0011;
  localparam cond_t COND_MI  = 4'b0100;
  localparam cond_t COND_PL  = 4'b0101;
  localparam cond_t COND_VS  = 4'b0110;
  localparam cond_t COND_VC  = 4'b0111;
  localparam cond_t COND_HI  = 4'b1000;
  localparam cond_t COND_LS  = 4'b1001;
  localparam cond_t COND_GE  = 4'b1010;
  localparam cond_t COND_LT  = 4'b1011;
  localparam cond_t COND_GT  = 4'b1100;
  localparam cond_t COND_LE  = 4'b1101;
  localparam cond_t COND_AL  = 4'b1110;
  localparam cond_t COND_UNC = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation of a condition field against
// the stored NZCV flags.
module cond_check
  import arm_pkg::*;
(
  input  cond_t      cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      COND_EQ:  pass_o = z;
      COND_NE:  pass_o = ~z;
      COND_CS:  pass_o = c;
      COND_CC:  pass_o = ~c;
      COND_MI:  pass_o = n;
      COND_PL:  pass_o = ~n;
      COND_VS:  pass_o = v;
      COND_VC:  pass_o = ~v;
      COND_HI:  pass_o = c & ~z;
      COND_LS:  pass_o = ~c | z;
      COND_GE:  pass_o = (n == v);
      COND_LT:  pass_o = (n != v);
      COND_GT:  pass_o = ~z & (n == v);
      COND_LE:  pass_o = z | (n != v);
      COND_AL:  pass_o = 1'b1;
      COND_UNC: pass_o = 1'b1;
      default:  pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Flags/condition stage after the ALU: holds NZCV, registers the condition
// result, gates the write enables and registers the ALU results.
module cond_unit
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  cond_t            Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             LongW,
  input  logic [WIDTH-1:0] Result32,
  input  logic [WIDTH-1:0] Result64,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ALUOutHi
);

  logic             cond_pass;
  logic [3:0]       flags_q,      flags_d;
  logic             cond_ex_q,    cond_ex_d;
  logic [WIDTH-1:0] alu_out_q,    alu_out_d;
  logic [WIDTH-1:0] alu_out_hi_q, alu_out_hi_d;

  // Condition is judged on the flags already stored, not on ALUFlags.
  cond_check u_cond_check (
    .cond_i  (Cond),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

  always_comb begin
    flags_d = flags_q;
    if (FlagW[1] && cond_pass) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (FlagW[0] && cond_pass) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
    cond_ex_d    = cond_pass;
    alu_out_d    = Result32;
    alu_out_hi_d = LongW ? Result64 : alu_out_hi_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q      <= 4'b0000;
      cond_ex_q    <= 1'b0;
      alu_out_q    <= '0;
      alu_out_hi_q <= '0;
    end else begin
      flags_q      <= flags_d;
      cond_ex_q    <= cond_ex_d;
      alu_out_q    <= alu_out_d;
      alu_out_hi_q <= alu_out_hi_d;
    end
  end

  // NextPC is the fetch advance and must not be blocked by a failed condition.
  assign PCWrite  = (PCS & cond_ex_q) | NextPC;
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;

  assign Flags    = flags_q;
  assign CondEx   = cond_ex_q;
  assign ALUOut   = alu_out_q;
  assign ALUOutHi = alu_out_hi_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed vector table, hand-written long-result and
// async-reset sequences, then random traffic against a behavioural model.
module tb_cond_unit;

  localparam int W    = 32;
  localparam int SB_W = 4 + 1 + 1 + 1 + 1 + W + W;

  logic         clk;
  logic         reset;
  logic [3:0]   Cond;
  logic [3:0]   ALUFlags;
  logic [1:0]   FlagW;
  logic         PCS, NextPC, RegW, MemW, LongW;
  logic [W-1:0] Result32, Result64;
  logic [3:0]   Flags;
  logic         CondEx, PCWrite, RegWrite, MemWrite;
  logic [W-1:0] ALUOut, ALUOutHi;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [SB_W-1:0] exp_q[$];

  // Reference state
  logic [3:0]   m_flags;
  logic         m_cx;
  logic [W-1:0] m_out, m_hi;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] fw;
    logic [3:0] af;
    logic       pcs, npc, rw, mw;
    logic [3:0] e_flags;
    logic       e_cx, e_pcw, e_rw, e_mw;
  } vec_t;

  vec_t tbl[20];

  cond_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .LongW    (LongW),
    .Result32 (Result32),
    .Result64 (Result64),
    .Flags    (Flags),
    .CondEx   (CondEx),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .ALUOut   (ALUOut),
    .ALUOutHi (ALUOutHi)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Condition meaning: pairs of codes share a base test, odd code inverts it.
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_cx    = 1'b0;
    m_out   = '0;
    m_hi    = '0;
  endtask

  task automatic model_edge();
    logic p;
    p = model_pass(Cond, m_flags);
    if (FlagW[1] && p) m_flags[3:2] = ALUFlags[3:2];
    if (FlagW[0] && p) m_flags[1:0] = ALUFlags[1:0];
    m_cx  = p;
    m_out = Result32;
    if (LongW) m_hi = Result64;
  endtask

  function automatic logic [SB_W-1:0] model_vec();
    return {m_flags, m_cx, (PCS & m_cx) | NextPC, RegW & m_cx, MemW & m_cx, m_out, m_hi};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic compare_pop();
    logic [SB_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard: got empty queue required entry");
      return;
    end
    e = exp_q.pop_front();
    check("Flags",    {28'd0, Flags},    {28'd0, e[SB_W-1 -: 4]});
    check("CondEx",   {31'd0, CondEx},   {31'd0, e[2*W+3]});
    check("PCWrite",  {31'd0, PCWrite},  {31'd0, e[2*W+2]});
    check("RegWrite", {31'd0, RegWrite}, {31'd0, e[2*W+1]});
    check("MemWrite", {31'd0, MemWrite}, {31'd0, e[2*W]});
    check("ALUOut",   ALUOut,   e[2*W-1 -: W]);
    check("ALUOutHi", ALUOutHi, e[W-1:0]);
  endtask

  // Driver: inputs are already applied; run one edge and check.
  task automatic step_with(input logic [SB_W-1:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic step_model();
    model_edge();
    step_with(model_vec());
  endtask

  task automatic drive_random();
    Cond     = 4'($urandom_range(0, 15));
    ALUFlags = 4'($urandom_range(0, 15));
    FlagW    = 2'($urandom_range(0, 3));
    PCS      = 1'($urandom_range(0, 1));
    NextPC   = ($urandom_range(0, 3) == 0);
    RegW     = 1'($urandom_range(0, 1));
    MemW     = 1'($urandom_range(0, 1));
    LongW    = 1'($urandom_range(0, 1));
    Result32 = $urandom;
    Result64 = $urandom;
  endtask

  initial begin
    tbl[0]  = '{4'hE, 2'b11, 4'h4, 0,0,0,0, 4'h4, 1,0,0,0};
    tbl[1]  = '{4'h0, 2'b00, 4'h0, 0,0,1,0, 4'h4, 1,0,1,0};
    tbl[2]  = '{4'h1, 2'b11, 4'hB, 0,0,0,0, 4'h4, 0,0,0,0};
    tbl[3]  = '{4'h1, 2'b00, 4'h0, 1,0,1,1, 4'h4, 0,0,0,0};
    tbl[4]  = '{4'h1, 2'b00, 4'h0, 1,1,1,1, 4'h4, 0,1,0,0};
    tbl[5]  = '{4'hE, 2'b11, 4'hF, 0,0,0,0, 4'hF, 1,0,0,0};
    tbl[6]  = '{4'hE, 2'b10, 4'h0, 0,0,0,0, 4'h3, 1,0,0,0};
    tbl[7]  = '{4'hE, 2'b01, 4'h0, 0,0,0,0, 4'h0, 1,0,0,0};
    tbl[8]  = '{4'hE, 2'b11, 4'h8, 0,0,0,0, 4'h8, 1,0,0,0};
    tbl[9]  = '{4'hA, 2'b00, 4'h0, 0,0,1,0, 4'h8, 0,0,0,0};
    tbl[10] = '{4'hB, 2'b00, 4'h0, 0,0,1,1, 4'h8, 1,0,1,1};
    tbl[11] = '{4'hC, 2'b00, 4'h0, 1,0,0,0, 4'h8, 0,0,0,0};
    tbl[12] = '{4'hD, 2'b00, 4'h0, 1,0,0,0, 4'h8, 1,1,0,0};
    tbl[13] = '{4'hE, 2'b11, 4'h9, 0,0,0,0, 4'h9, 1,0,0,0};
    tbl[14] = '{4'hA, 2'b00, 4'h0, 0,0,0,0, 4'h9, 1,0,0,0};
    tbl[15] = '{4'hB, 2'b00, 4'h0, 0,0,0,0, 4'h9, 0,0,0,0};
    tbl[16] = '{4'hE, 2'b11, 4'h2, 0,0,0,0, 4'h2, 1,0,0,0};
    tbl[17] = '{4'h8, 2'b00, 4'h0, 0,0,1,0, 4'h2, 1,0,1,0};
    tbl[18] = '{4'h9, 2'b00, 4'h0, 0,0,1,0, 4'h2, 0,0,0,0};
    tbl[19] = '{4'hF, 2'b11, 4'h5, 0,0,0,0, 4'h5, 1,0,0,0};

    // Reset held with random inputs
    reset = 1'b0;
    drive_random();
    NextPC = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      drive_random();
      NextPC = 1'b1;
      RegW   = 1'b1;
      MemW   = 1'b1;
      #1;
      check("rst_Flags",    {28'd0, Flags},    32'd0);
      check("rst_CondEx",   {31'd0, CondEx},   32'd0);
      check("rst_ALUOut",   ALUOut,   32'd0);
      check("rst_ALUOutHi", ALUOutHi, 32'd0);
      check("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
      check("rst_MemWrite", {31'd0, MemWrite}, 32'd0);
      check("rst_PCWrite",  {31'd0, PCWrite},  32'd1);
    end
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      Cond = tbl[i].cond; FlagW = tbl[i].fw; ALUFlags = tbl[i].af;
      PCS = tbl[i].pcs; NextPC = tbl[i].npc; RegW = tbl[i].rw; MemW = tbl[i].mw;
      LongW = 1'b0; Result32 = $urandom; Result64 = $urandom;
      model_edge();
      step_with({tbl[i].e_flags, tbl[i].e_cx, tbl[i].e_pcw, tbl[i].e_rw, tbl[i].e_mw, m_out, m_hi});
    end

    // Long multiply result and hold
    Cond = 4'hE; FlagW = 2'b00; ALUFlags = 4'h0;
    PCS = 0; NextPC = 0; RegW = 0; MemW = 0;
    Result32 = 32'h89AB_CDEF; Result64 = 32'h0123_4567; LongW = 1'b1;
    @(posedge clk);
    #1;
    check("long_ALUOut",   ALUOut,   32'h89AB_CDEF);
    check("long_ALUOutHi", ALUOutHi, 32'h0123_4567);
    LongW = 1'b0; Result64 = 32'hFFFF_FFFF; Result32 = 32'h1357_9BDF;
    @(posedge clk);
    #1;
    check("hold_ALUOutHi", ALUOutHi, 32'h0123_4567);
    check("hold_ALUOut",   ALUOut,   32'h1357_9BDF);

    // Reset asserted between edges clears state without waiting for a clock
    #2;
    RegW = 1'b1;
    reset = 1'b0;
    #1;
    check("async_ALUOut",   ALUOut,   32'd0);
    check("async_ALUOutHi", ALUOutHi, 32'd0);
    check("async_Flags",    {28'd0, Flags},    32'd0);
    check("async_RegWrite", {31'd0, RegWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive_random();
      step_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
